// File: rtl/lut_eval_if.sv
// lut_eval_if: load, evaluate and sweep signals between stimulus logic and lut_eval_seq.
interface lut_eval_if #(
    parameter int N_IN = 3
);
    logic            load_valid, load_bit, load_ready, load_done;
    logic            in_valid, z, z_valid;
    logic            sweep_start, sweep_busy, sweep_done, tt_err;
    logic [N_IN-1:0] in_vec;
    logic [N_IN:0]   ones_cnt;
    modport master (
        output load_valid, load_bit, in_valid, in_vec, sweep_start,
        input  load_ready, load_done, z, z_valid, sweep_busy, sweep_done, ones_cnt, tt_err
    );
    modport slave (
        input  load_valid, load_bit, in_valid, in_vec, sweep_start,
        output load_ready, load_done, z, z_valid, sweep_busy, sweep_done, ones_cnt, tt_err
    );
endinterface

// File: rtl/lut_eval_seq.sv
// lut_eval_seq: serially loaded N-input LUT with registered eval and an exhaustive ones-count sweep.
// Optional table parity checking is enabled by defining LUT_PARITY_CHK_EN.
module lut_eval_seq #(
    parameter int                   N_IN    = 3,
    parameter logic [(1<<N_IN)-1:0] INIT_TT = 'hE8
) (
    input logic       clk,
    input logic       rst_n,
    lut_eval_if.slave bus
);
    localparam int TT_W = 1 << N_IN;
    localparam int CW   = N_IN + 1;
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t          r_state, w_next;
    logic [TT_W-1:0] r_tt;
    logic [N_IN-1:0] r_load_cnt, r_idx;
    logic [CW-1:0]   r_acc, r_ones;
    logic            r_z, r_z_valid, r_load_done, r_sweep_done;
    logic            w_idle, w_sweep_go, w_load_go, w_eval_go, w_last;

    // Same-cycle priority in IDLE: sweep_start, then load, then eval
    assign w_idle     = r_state == IDLE;
    assign w_sweep_go = w_idle && bus.sweep_start;
    assign w_load_go  = w_idle && !bus.sweep_start && bus.load_valid;
    assign w_eval_go  = w_idle && !bus.sweep_start && !bus.load_valid && bus.in_valid;
    assign w_last     = r_state == SWEEP && &r_idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb w_next = w_sweep_go ? SWEEP : (w_last ? IDLE : r_state);

    always_comb begin
        bus.load_ready = w_idle;
        bus.sweep_busy = !w_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt         <= INIT_TT;
            r_load_cnt   <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_ones       <= '0;
            r_z          <= 1'b0;
            r_z_valid    <= 1'b0;
            r_load_done  <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_z_valid    <= w_eval_go;
            r_load_done  <= w_load_go && &r_load_cnt;
            r_sweep_done <= w_last;
            if (w_eval_go) r_z <= r_tt[bus.in_vec];
            if (w_load_go) begin
                r_tt       <= {bus.load_bit, r_tt[TT_W-1:1]};
                r_load_cnt <= r_load_cnt + N_IN'(1);
            end
            if (w_sweep_go) r_acc <= '0;
            // idx wraps back to 0 on the final sweep cycle
            if (r_state == SWEEP) begin
                r_acc <= r_acc + CW'(r_tt[r_idx]);
                r_idx <= r_idx + N_IN'(1);
            end
            if (w_last) r_ones <= r_acc + CW'(r_tt[r_idx]);
        end
    end

    assign bus.z          = r_z;
    assign bus.z_valid    = r_z_valid;
    assign bus.load_done  = r_load_done;
    assign bus.sweep_done = r_sweep_done;
    assign bus.ones_cnt   = r_ones;

`ifdef LUT_PARITY_CHK_EN
    logic r_par, r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= ^INIT_TT;
            r_err <= 1'b0;
        end else begin
            if (r_load_done) r_par <= ^r_tt;
            if ((w_eval_go || r_state == SWEEP) && (^r_tt != r_par)) r_err <= 1'b1;
        end
    end
    assign bus.tt_err = r_err;
`else
    assign bus.tt_err = 1'b0;
`endif
endmodule

// File: tb/tb_lut_eval_seq.sv
// tb_lut_eval_seq: directed bench for lut_eval_seq with queue scoreboards for z and ones_cnt.
module tb_lut_eval_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         n;
    logic [7:0] m_tt = 8'hE8;
    bit         q_z[$];
    int         q_ones[$];

    lut_eval_if #(.N_IN(3)) bus ();
    lut_eval_seq #(.N_IN(3), .INIT_TT(8'hE8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.load_valid  = 1'b0;
        bus.load_bit    = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_vec      = '0;
        bus.sweep_start = 1'b0;
    endtask

    task automatic pop_z();
        chk("sb_z_nonempty", q_z.size() != 0, 1);
        if (q_z.size() != 0) chk("z", bus.z, q_z.pop_front());
    endtask

    task automatic eval_one(input logic [2:0] v);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        q_z.push_back(m_tt[v]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("z_valid", bus.z_valid, 1);
        pop_z();
        @(negedge clk);
        chk("z_valid_pulse", bus.z_valid, 0);
    endtask

    task automatic load_tt(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            bus.load_valid = 1'b1;
            bus.load_bit   = v[i];
            @(negedge clk);
            if (i == 6) chk("load_done_early", bus.load_done, 0);
        end
        m_tt = v;
        chk("load_done", bus.load_done, 1);
        bus.load_valid = 1'b0;
        @(negedge clk);
        chk("load_done_pulse", bus.load_done, 0);
    endtask

    // Caller may pre-drive competing requests; they must all lose to sweep_start
    task automatic sweep();
        bus.sweep_start = 1'b1;
        q_ones.push_back($countones(m_tt));
        @(negedge clk);
        idle_inputs();
        chk("sweep_z_valid", bus.z_valid, 0);
        chk("sweep_load_ready", bus.load_ready, 0);
        n = 0;
        while (bus.sweep_busy && n < 20) begin
            n++;
            bus.in_valid    = 1'b1;
            bus.load_valid  = 1'b1;
            bus.load_bit    = 1'b1;
            bus.sweep_start = 1'b1;
            @(negedge clk);
            chk("sweep_ignore_eval", bus.z_valid, 0);
        end
        idle_inputs();
        chk("sweep_busy_cycles", n, 8);
        chk("sweep_done", bus.sweep_done, 1);
        chk("sb_ones_nonempty", q_ones.size() != 0, 1);
        if (q_ones.size() != 0) chk("ones_cnt", bus.ones_cnt, q_ones.pop_front());
        @(negedge clk);
        chk("sweep_done_pulse", bus.sweep_done, 0);
        chk("sweep_ready_back", bus.load_ready, 1);
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_z", bus.z, 0);
        chk("rst_z_valid", bus.z_valid, 0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_sweep_busy", bus.sweep_busy, 0);
        chk("rst_sweep_done", bus.sweep_done, 0);
        chk("rst_ones_cnt", bus.ones_cnt, 0);
        chk("rst_tt_err", bus.tt_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_load_ready", bus.load_ready, 1);

        eval_one(3'b011);
        eval_one(3'b100);
        sweep();

        bus.load_valid = 1'b1;
        bus.load_bit   = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_vec     = 3'b011;
        sweep();
        eval_one(3'b011);
        eval_one(3'b111);

        load_tt(8'h69);
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'd0;
        q_z.push_back(m_tt[0]);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b_z_valid", bus.z_valid, 1);
            pop_z();
            if (i < 8) begin
                bus.in_vec = 3'(i);
                q_z.push_back(m_tt[i]);
            end else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_z_valid_end", bus.z_valid, 0);
        sweep();

        load_tt(8'hFF);
        sweep();
        eval_one(3'd5);

        bus.sweep_start = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.sweep_busy, 0);
        chk("abort_done", bus.sweep_done, 0);
        chk("abort_ones_cnt", bus.ones_cnt, 0);
        chk("abort_z", bus.z, 0);
        chk("abort_z_valid", bus.z_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_tt  = 8'hE8;
        @(negedge clk);
        eval_one(3'b011);
        eval_one(3'b100);
        sweep();

`ifdef LUT_PARITY_CHK_EN
        load_tt(8'h69);
        eval_one(3'd3);
        chk("par_clean", bus.tt_err, 0);
        force dut.r_tt[0] = 1'b0;
        m_tt[0] = 1'b0;
        eval_one(3'd0);
        release dut.r_tt[0];
        chk("par_err", bus.tt_err, 1);
        repeat (3) @(negedge clk);
        chk("par_err_sticky", bus.tt_err, 1);
`else
        chk("tt_err_off", bus.tt_err, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
